// File: rtl/ifetch_unit_pkg.sv
// Shared fetch-path definitions: cache geometry, RVC marker, FSM encoding and
// the halfword/straddle instruction assembly helper.
package ifetch_unit_pkg;

  localparam int unsigned ROB_WIDTH          = 4;
  localparam int unsigned ICACHE_INDEX_WIDTH = 6;
  localparam logic [1:0]  RVC_LOW            = 2'b11;
  localparam int unsigned XLEN               = 32;
  localparam int unsigned WORD_AW            = 30;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_FILL = 1'b1;

  typedef struct packed {
    logic            is_c;
    logic            need_w1;
    logic [XLEN-1:0] inst;
  } fetch_rsp_t;

  // Builds the response from the two consecutive words; need_w1 flags a straddle.
  function automatic fetch_rsp_t assemble(input logic pc_half,
                                          input logic [XLEN-1:0] w0,
                                          input logic [XLEN-1:0] w1);
    fetch_rsp_t r;
    logic [15:0] half;
    half      = pc_half ? w0[31:16] : w0[15:0];
    r.is_c    = (half[1:0] != RVC_LOW);
    r.need_w1 = pc_half && !r.is_c;
    if (r.is_c)
      r.inst = {16'h0000, half};
    else if (pc_half)
      r.inst = {w1[15:0], w0[31:16]};
    else
      r.inst = w0;
    return r;
  endfunction

endpackage

// File: rtl/ifetch_unit_if.sv
// Word-read port between the fetch unit (master) and the memory controller.
interface ifetch_unit_if;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ready;
  logic [31:0] mem_data;

  modport master (output mem_req, output mem_addr, input mem_ready, input mem_data);
  modport slave  (input mem_req, input mem_addr, output mem_ready, output mem_data);
endinterface

// File: rtl/ifetch_unit_bank.sv
// One direct-mapped instruction word bank: combinational read, synchronous
// write, valid vector cleared synchronously on reset.
module icache_bank #(
  parameter int unsigned IDX_W = 6,
  parameter int unsigned TAG_W = 23
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [IDX_W-1:0] rd_set_i,
  input  logic [TAG_W-1:0] rd_tag_i,
  output logic             rd_hit_c_o,
  output logic [31:0]      rd_data_c_o,
  input  logic             we_i,
  input  logic [IDX_W-1:0] wr_set_i,
  input  logic [TAG_W-1:0] wr_tag_i,
  input  logic [31:0]      wr_data_i
);
  localparam int unsigned DEPTH = 1 << IDX_W;

  logic [DEPTH-1:0] valid_q;
  logic [TAG_W-1:0] tag_q  [DEPTH];
  logic [31:0]      data_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (rst_i)
      valid_q <= '0;
    else if (we_i)
      valid_q[wr_set_i] <= 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      tag_q[wr_set_i]  <= wr_tag_i;
      data_q[wr_set_i] <= wr_data_i;
    end
  end

  assign rd_hit_c_o  = valid_q[rd_set_i] && (tag_q[rd_set_i] == rd_tag_i);
  assign rd_data_c_o = data_q[rd_set_i];
endmodule

// File: rtl/ifetch_unit.sv
// Instruction fetch responder: two-bank I-cache lookup (straddle in one cycle),
// miss refill FSM and registered response/memory-request outputs.
module ifetch_unit #(
  parameter int unsigned ICACHE_INDEX_WIDTH = ifetch_unit_pkg::ICACHE_INDEX_WIDTH
) (
  input  logic               clk_in,
  input  logic               rst_in,
  input  logic               rdy_in,
  input  logic               clear,
  input  logic               if_enable,
  input  logic [31:0]        if_addr,
  output logic               inst_ready,
  output logic               is_c,
  output logic [31:0]        inst_val,
  ifetch_unit_if.master      mem
);
  import ifetch_unit_pkg::*;

  localparam int unsigned IDX   = ICACHE_INDEX_WIDTH;
  localparam int unsigned TAG_W = WORD_AW - IDX - 1;

  logic [0:0]         state_q, state_d;
  logic               inst_ready_q, inst_ready_d;
  logic               is_c_q, is_c_d;
  logic [31:0]        inst_val_q, inst_val_d;
  logic               mem_req_q, mem_req_d;
  logic [31:0]        mem_addr_q, mem_addr_d;
  logic               fill_we_c;

  logic [WORD_AW-1:0] w0_c, w1_c, ev_w_c, od_w_c, fill_w_c, miss_w_c;
  logic               ev_hit_c, od_hit_c, hit0_c, hit1_c, hit_c;
  logic [31:0]        ev_data_c, od_data_c, data0_c, data1_c;
  fetch_rsp_t         rsp_c;
  logic               unused_pc0;

  assign unused_pc0 = if_addr[0];

  // W0 and W1 always land in opposite banks; route each to the right one.
  assign w0_c   = if_addr[31:2];
  assign w1_c   = w0_c + WORD_AW'(1);
  assign ev_w_c = w0_c[0] ? w1_c : w0_c;
  assign od_w_c = w0_c[0] ? w0_c : w1_c;
  assign fill_w_c = mem_addr_q[31:2];

  icache_bank #(.IDX_W(IDX), .TAG_W(TAG_W)) u_bank_even (
    .clk_i       (clk_in),
    .rst_i       (rst_in),
    .rd_set_i    (ev_w_c[IDX:1]),
    .rd_tag_i    (ev_w_c[WORD_AW-1:IDX+1]),
    .rd_hit_c_o  (ev_hit_c),
    .rd_data_c_o (ev_data_c),
    .we_i        (fill_we_c && !fill_w_c[0]),
    .wr_set_i    (fill_w_c[IDX:1]),
    .wr_tag_i    (fill_w_c[WORD_AW-1:IDX+1]),
    .wr_data_i   (mem.mem_data)
  );

  icache_bank #(.IDX_W(IDX), .TAG_W(TAG_W)) u_bank_odd (
    .clk_i       (clk_in),
    .rst_i       (rst_in),
    .rd_set_i    (od_w_c[IDX:1]),
    .rd_tag_i    (od_w_c[WORD_AW-1:IDX+1]),
    .rd_hit_c_o  (od_hit_c),
    .rd_data_c_o (od_data_c),
    .we_i        (fill_we_c && fill_w_c[0]),
    .wr_set_i    (fill_w_c[IDX:1]),
    .wr_tag_i    (fill_w_c[WORD_AW-1:IDX+1]),
    .wr_data_i   (mem.mem_data)
  );

  assign hit0_c  = w0_c[0] ? od_hit_c  : ev_hit_c;
  assign hit1_c  = w0_c[0] ? ev_hit_c  : od_hit_c;
  assign data0_c = w0_c[0] ? od_data_c : ev_data_c;
  assign data1_c = w0_c[0] ? ev_data_c : od_data_c;

  assign rsp_c    = assemble(if_addr[1], data0_c, data1_c);
  assign hit_c    = hit0_c && (!rsp_c.need_w1 || hit1_c);
  assign miss_w_c = hit0_c ? w1_c : w0_c;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q      <= ST_IDLE;
      inst_ready_q <= 1'b0;
      is_c_q       <= 1'b0;
      inst_val_q   <= '0;
      mem_req_q    <= 1'b0;
      mem_addr_q   <= '0;
    end else begin
      state_q      <= state_d;
      inst_ready_q <= inst_ready_d;
      is_c_q       <= is_c_d;
      inst_val_q   <= inst_val_d;
      mem_req_q    <= mem_req_d;
      mem_addr_q   <= mem_addr_d;
    end
  end

  // A flushed request in IDLE is dropped outright; a fill in flight always completes.
  always_comb begin
    state_d      = state_q;
    inst_ready_d = inst_ready_q;
    is_c_d       = is_c_q;
    inst_val_d   = inst_val_q;
    mem_req_d    = mem_req_q;
    mem_addr_d   = mem_addr_q;
    fill_we_c    = 1'b0;
    if (rdy_in) begin
      inst_ready_d = 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (if_enable && !clear) begin
            if (hit_c) begin
              inst_ready_d = 1'b1;
              is_c_d       = rsp_c.is_c;
              inst_val_d   = rsp_c.inst;
            end else begin
              state_d    = ST_FILL;
              mem_req_d  = 1'b1;
              mem_addr_d = {miss_w_c, 2'b00};
            end
          end
        end
        ST_FILL: begin
          if (mem.mem_ready) begin
            fill_we_c = !rst_in;
            state_d   = ST_IDLE;
            mem_req_d = 1'b0;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  assign inst_ready   = inst_ready_q;
  assign is_c         = is_c_q;
  assign inst_val     = inst_val_q;
  assign mem.mem_req  = mem_req_q;
  assign mem.mem_addr = mem_addr_q;
endmodule

// File: tb/tb_ifetch_unit.sv
// Directed bench for ifetch_unit: word-granular cache model checked every
// cycle, plus literal expectations for the documented scenarios.
module tb_ifetch_unit;

  logic        clk_in = 1'b1;
  logic        rst_in, rdy_in, clear, if_enable;
  logic [31:0] if_addr;
  logic        inst_ready, is_c;
  logic [31:0] inst_val;

  ifetch_unit_if mem_if ();

  ifetch_unit #(.ICACHE_INDEX_WIDTH(6)) dut (
    .clk_in     (clk_in),
    .rst_in     (rst_in),
    .rdy_in     (rdy_in),
    .clear      (clear),
    .if_enable  (if_enable),
    .if_addr    (if_addr),
    .inst_ready (inst_ready),
    .is_c       (is_c),
    .inst_val   (inst_val),
    .mem        (mem_if)
  );

  always #5 clk_in = ~clk_in;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, need 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case ({a[31:2], 2'b00})
      32'h0000_0000: return 32'h0050_0093;
      32'h0000_0008: return 32'h0085_4505;
      32'h0000_0010: return 32'h0093_0000;
      32'h0000_0014: return 32'hFFFF_0050;
      32'h0000_0040: return 32'h0100_0113;
      32'h0000_01FC: return 32'h0513_0001;
      32'h0000_0200: return 32'hABCD_0050;
      default:       return {a[31:2], 2'b11};
    endcase
  endfunction

  // Memory responder: ack after mem_lat waiting cycles; 'stray' injects an unsolicited ack.
  bit mem_auto = 1'b1;
  bit stray    = 1'b0;
  int mem_lat  = 2;
  int wcnt     = 0;

  always @(negedge clk_in) begin
    mem_if.mem_ready = 1'b0;
    mem_if.mem_data  = 32'h0;
    if (stray) begin
      mem_if.mem_ready = 1'b1;
      mem_if.mem_data  = 32'hDEAD_BEEF;
      stray = 1'b0;
    end else if (!mem_if.mem_req) begin
      wcnt = 0;
    end else if (mem_auto) begin
      if (wcnt >= mem_lat) begin
        mem_if.mem_ready = 1'b1;
        mem_if.mem_data  = mem_word(mem_if.mem_addr);
        wcnt = 0;
      end else begin
        wcnt++;
      end
    end
  end

  logic [31:0] fills[$];
  always @(posedge clk_in)
    if (!rst_in && rdy_in && mem_if.mem_req && mem_if.mem_ready)
      fills.push_back(mem_if.mem_addr);

  // Model: 128-word direct-mapped cache (slot = word index mod 128), one fill at a time.
  bit          c_valid [128];
  logic [29:0] c_word  [128];
  logic [31:0] c_data  [128];
  bit          m_fill, m_ready, m_isc, m_req;
  logic [31:0] m_val, m_addr;

  function automatic bit c_hit(input logic [29:0] w);
    return c_valid[w[6:0]] && (c_word[w[6:0]] == w);
  endfunction

  always @(posedge clk_in) begin : model
    logic [29:0] w0, w1;
    logic [31:0] d0, d1;
    logic [15:0] half;
    bit          cmp, need1;
    if (rst_in) begin
      m_fill = 0; m_ready = 0; m_isc = 0; m_req = 0; m_val = 0; m_addr = 0;
      for (int i = 0; i < 128; i++) c_valid[i] = 0;
    end else if (rdy_in) begin
      m_ready = 0;
      if (!m_fill) begin
        if (if_enable && !clear) begin
          w0 = if_addr[31:2];
          w1 = w0 + 30'd1;
          d0 = c_data[w0[6:0]];
          d1 = c_data[w1[6:0]];
          half  = if_addr[1] ? d0[31:16] : d0[15:0];
          cmp   = (half[1:0] != 2'b11);
          need1 = if_addr[1] && !cmp;
          if (c_hit(w0) && (!need1 || c_hit(w1))) begin
            m_ready = 1;
            m_isc   = cmp;
            m_val   = cmp ? {16'h0, half} : (if_addr[1] ? {d1[15:0], d0[31:16]} : d0);
          end else begin
            m_fill = 1;
            m_req  = 1;
            m_addr = c_hit(w0) ? {w1, 2'b00} : {w0, 2'b00};
          end
        end
      end else if (mem_if.mem_ready) begin
        c_valid[m_addr[8:2]] = 1;
        c_word[m_addr[8:2]]  = m_addr[31:2];
        c_data[m_addr[8:2]]  = mem_if.mem_data;
        m_fill = 0;
        m_req  = 0;
      end
    end
  end

  bit cmp_en = 1'b0;
  always @(negedge clk_in) begin
    if (cmp_en) begin
      check("cyc_inst_ready", 32'(inst_ready), 32'(m_ready));
      check("cyc_is_c", 32'(is_c), 32'(m_isc));
      check("cyc_inst_val", inst_val, m_val);
      check("cyc_mem_req", 32'(mem_if.mem_req), 32'(m_req));
      check("cyc_mem_addr", mem_if.mem_addr, m_addr);
    end
  end

  task automatic fetch(input logic [31:0] a, output logic [31:0] val, output logic c,
                       output int cyc);
    if_enable = 1'b1;
    if_addr   = a;
    cyc       = 0;
    do begin
      @(negedge clk_in);
      cyc++;
    end while (!inst_ready && cyc < 50);
    if (!inst_ready) begin
      n_vec++;
      n_err++;
      $display("FAIL fetch_timeout addr=0x%08h: no inst_ready after %0d cycles", a, cyc);
    end
    val = inst_val;
    c   = is_c;
  endtask

  task automatic idle(input int n);
    if_enable = 1'b0;
    repeat (n) @(negedge clk_in);
  endtask

  task automatic wait_req(input string name);
    int k = 0;
    while (!mem_if.mem_req && k < 20) begin
      @(negedge clk_in);
      k++;
    end
    check(name, 32'(mem_if.mem_req), 32'd1);
  endtask

  logic [31:0] v;
  logic        c;
  int          cyc;
  int          seen_ready;

  initial begin
    rst_in = 1'b1; rdy_in = 1'b1; clear = 1'b0; if_enable = 1'b0; if_addr = 32'h0;
    repeat (2) @(negedge clk_in);
    check("rst_inst_ready", 32'(inst_ready), 32'd0);
    check("rst_is_c", 32'(is_c), 32'd0);
    check("rst_inst_val", inst_val, 32'd0);
    check("rst_mem_req", 32'(mem_if.mem_req), 32'd0);
    check("rst_mem_addr", mem_if.mem_addr, 32'd0);
    cmp_en = 1'b1;
    rst_in = 1'b0;

    // Cold miss
    fills.delete();
    fetch(32'h0, v, c, cyc);
    check("cold_val", v, 32'h0050_0093);
    check("cold_is_c", 32'(c), 32'd0);
    check("cold_latency", 32'(cyc), 32'd5);
    check("cold_nfills", 32'(fills.size()), 32'd1);
    check("cold_fill_addr", fills[0], 32'h0);
    idle(1);

    // Compressed pair, back to back once cached
    fetch(32'h8, v, c, cyc);
    idle(1);
    fetch(32'h8, v, c, cyc);
    check("pair0_val", v, 32'h0000_4505);
    check("pair0_is_c", 32'(c), 32'd1);
    check("pair0_latency", 32'(cyc), 32'd1);
    fetch(32'hA, v, c, cyc);
    check("pair1_val", v, 32'h0000_0085);
    check("pair1_is_c", 32'(c), 32'd1);
    check("pair1_latency", 32'(cyc), 32'd1);
    idle(1);

    // Straddle with both words missing
    fills.delete();
    fetch(32'h12, v, c, cyc);
    check("strad_val", v, 32'h0050_0093);
    check("strad_is_c", 32'(c), 32'd0);
    check("strad_latency", 32'(cyc), 32'd9);
    check("strad_nfills", 32'(fills.size()), 32'd2);
    check("strad_fill0", fills[0], 32'h10);
    check("strad_fill1", fills[1], 32'h14);
    idle(1);

    // Set wrap: W1=0x200 collides with the stale word-0 line
    fills.delete();
    fetch(32'h1FE, v, c, cyc);
    check("wrap_val", v, 32'h0050_0513);
    check("wrap_latency", 32'(cyc), 32'd9);
    check("wrap_nfills", 32'(fills.size()), 32'd2);
    check("wrap_fill1", fills[1], 32'h200);
    idle(1);
    fetch(32'h0, v, c, cyc);
    check("evicted_latency", 32'(cyc), 32'd5);
    check("evicted_val", v, 32'h0050_0093);
    idle(1);

    // Clear during FILL
    if_enable = 1'b1;
    if_addr   = 32'h40;
    wait_req("clr_req_rise");
    clear = 1'b1;
    @(negedge clk_in);
    clear = 1'b0;
    if_enable = 1'b0;
    check("clr_req_held", 32'(mem_if.mem_req), 32'd1);
    seen_ready = 0;
    for (int k = 0; k < 20 && mem_if.mem_req; k++) begin
      @(negedge clk_in);
      if (inst_ready) seen_ready++;
    end
    @(negedge clk_in);
    if (inst_ready) seen_ready++;
    check("clr_no_ready", 32'(seen_ready), 32'd0);
    idle(1);
    fetch(32'h40, v, c, cyc);
    check("clr_cached_latency", 32'(cyc), 32'd1);
    check("clr_cached_val", v, 32'h0100_0113);
    idle(1);

    // Reset mid-FILL, then a stray ack while idle
    mem_auto  = 1'b0;
    if_enable = 1'b1;
    if_addr   = 32'h80;
    wait_req("rstfill_req_rise");
    if_enable = 1'b0;
    rst_in    = 1'b1;
    @(negedge clk_in);
    check("rstfill_req_low", 32'(mem_if.mem_req), 32'd0);
    check("rstfill_ready_low", 32'(inst_ready), 32'd0);
    rst_in = 1'b0;
    stray  = 1'b1;
    idle(3);
    check("stray_req_low", 32'(mem_if.mem_req), 32'd0);
    mem_auto = 1'b1;
    fetch(32'h8, v, c, cyc);
    check("post_rst_latency", 32'(cyc), 32'd5);
    check("post_rst_val", v, 32'h0000_4505);
    idle(1);

    // rdy_in low holds the response
    fetch(32'h8, v, c, cyc);
    if_enable = 1'b0;
    rdy_in    = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk_in);
      check("hold_ready", 32'(inst_ready), 32'd1);
      check("hold_val", inst_val, 32'h0000_4505);
    end
    rdy_in = 1'b1;
    @(negedge clk_in);
    check("release_ready", 32'(inst_ready), 32'd0);
    idle(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
